trace_arbiter: RTL

- Owns the single port of the trace buffer and shares it between three requesters: render read-out (visible region), tracer column writes (queued), and a debug fill sweep (VBLANK only).
- Sits between tracer/vga_sync and trace_buffer, so the tracer no longer drives the buffer directly.
- Tracer writes are decoupled by a small FIFO with a valid/ready handshake, so the tracer need not align its stores with blanking.

---
 rtl/raybox_pkg.sv | 27 ++
 rtl/trace_arbiter_if.sv | 21 ++
 rtl/trace_fifo.sv | 47 ++++
 rtl/trace_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/raybox_pkg.sv
// Shared raybox types and screen geometry used by tracer, trace_arbiter and trace_buffer.
package raybox_pkg;

  localparam int unsigned COL_BITS      = 10;
  localparam int unsigned HEIGHT_BITS   = 8;
  localparam int unsigned SCREEN_WIDTH  = 640;
  localparam int unsigned SCREEN_HEIGHT = 480;

  typedef struct packed {
    logic [COL_BITS-1:0]    column;
    logic                   side;
    logic [HEIGHT_BITS-1:0] height;
  } trace_entry_t;

  typedef enum logic {
    SW_IDLE,
    SW_SWEEP
  } sweep_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RENDER,
    GNT_TRACER,
    GNT_DEBUG
  } grant_t;

endpackage

// File: rtl/trace_arbiter_if.sv
// Tracer -> arbiter column-result channel (valid/ready).
interface trace_arbiter_if #(
  parameter int unsigned COL_BITS    = 10,
  parameter int unsigned HEIGHT_BITS = 8
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [COL_BITS-1:0]    wr_column;
  logic                   wr_side;
  logic [HEIGHT_BITS-1:0] wr_height;

  modport master (
    output wr_valid, wr_column, wr_side, wr_height,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_column, wr_side, wr_height,
    output wr_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module trace_fifo #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_BITS:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (level == (PTR_BITS+1)'(DEPTH));
  assign empty   = (level == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (PTR_BITS+1)'(do_push) - (PTR_BITS+1)'(do_pop);
    end
  end

endmodule

// File: rtl/trace_arbiter.sv
// Shares the trace_buffer port between render read-out, queued tracer writes and a VBLANK debug sweep.
module trace_arbiter
  import raybox_pkg::*;
#(
  parameter int unsigned COL_BITS     = raybox_pkg::COL_BITS,
  parameter int unsigned HEIGHT_BITS  = raybox_pkg::HEIGHT_BITS,
  parameter int unsigned SCREEN_WIDTH = raybox_pkg::SCREEN_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned LVL_BITS    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   visible,
  input  logic [9:0]             h,
  input  logic                   vblank,
  trace_arbiter_if.slave         wr,
  input  logic [HEIGHT_BITS-1:0] dbg_height,
  output logic [COL_BITS-1:0]    buf_column,
  output logic                   buf_we,
  output logic                   buf_side,
  output logic [HEIGHT_BITS-1:0] buf_height,
  output logic [LVL_BITS-1:0]    fifo_level,
  output logic                   overflow,
  output logic                   sweep_busy
);

  localparam int unsigned ENTRY_W = COL_BITS + 1 + HEIGHT_BITS;

  typedef struct packed {
    logic [COL_BITS-1:0]    column;
    logic                   side;
    logic [HEIGHT_BITS-1:0] height;
  } entry_t;

  entry_t                 head;
  logic   [ENTRY_W-1:0]   head_raw;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   head_in_range;

  sweep_state_t           state_q, state_d;
  logic [COL_BITS-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic [HEIGHT_BITS-1:0] sweep_ht_q, sweep_ht_d;
  logic                   vblank_q;
  grant_t                 grant;

  assign wr.wr_ready = reset && !fifo_full;
  assign fifo_push   = wr.wr_valid && wr.wr_ready;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({wr.wr_column, wr.wr_side, wr.wr_height}),
    .dout  (head_raw),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head          = entry_t'(head_raw);
  assign head_in_range = ({1'b0, head.column} < (COL_BITS+1)'(SCREEN_WIDTH));
  assign sweep_busy    = (state_q == SW_SWEEP);

  // Debug only holds the port while vblank is still high, so an abort never writes the current column.
  always_comb begin
    grant = GNT_NONE;
    if (visible)                            grant = GNT_RENDER;
    else if (!fifo_empty)                   grant = GNT_TRACER;
    else if (state_q == SW_SWEEP && vblank) grant = GNT_DEBUG;
  end

  always_comb begin
    buf_column = COL_BITS'(h);
    buf_we     = 1'b0;
    buf_side   = 1'b0;
    buf_height = '0;
    fifo_pop   = 1'b0;
    unique case (grant)
      GNT_TRACER: begin
        buf_column = head.column;
        buf_side   = head.side;
        buf_height = head.height;
        buf_we     = reset && head_in_range;
        fifo_pop   = reset;
      end
      GNT_DEBUG: begin
        buf_column = sweep_cnt_q;
        buf_height = sweep_ht_q;
        buf_we     = reset;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    sweep_ht_d  = sweep_ht_q;
    unique case (state_q)
      SW_IDLE: begin
        if (vblank && !vblank_q && dbg_height != '0) begin
          state_d     = SW_SWEEP;
          sweep_ht_d  = dbg_height;
          sweep_cnt_d = '0;
        end
      end
      SW_SWEEP: begin
        if (!vblank) begin
          state_d     = SW_IDLE;
          sweep_cnt_d = '0;
        end else if (grant == GNT_DEBUG) begin
          if (sweep_cnt_q == COL_BITS'(SCREEN_WIDTH - 1)) begin
            state_d     = SW_IDLE;
            sweep_cnt_d = '0;
          end else begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SW_IDLE;
      sweep_cnt_q <= '0;
      sweep_ht_q  <= '0;
      vblank_q    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      sweep_ht_q  <= sweep_ht_d;
      vblank_q    <= vblank;
      overflow    <= overflow | (wr.wr_valid && !wr.wr_ready);
    end
  end

endmodule
